force_override_ctrl: RTL and testbench

Synthesizable, multi-channel force/release override unit: the hardware counterpart of procedural `force`/`release` on nets. It sits between a block's normally driven nets and their consumers. On command it substitutes a held value per channel, either permanently or for a timed window, and restores the live driven value on release. It lets hardware regressions and on-target debug override internal nets without recompiling the design.

---
 rtl/force_pkg.sv | 24 ++
 rtl/force_override_ctrl_if.sv | 26 ++
 rtl/force_chan.sv | 55 +++++
 rtl/force_override_ctrl.sv | 116 +++++++++++
 tb/tb_force_override_ctrl.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/force_pkg.sv
// Shared types for the force/release override unit: command opcodes, FSM states,
// and the channel-index width helper.
package force_pkg;

    localparam int unsigned OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        FORCE       = 2'd0,
        RELEASE     = 2'd1,
        TFORCE      = 2'd2,
        RELEASE_ALL = 2'd3
    } force_op_e;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } force_state_e;

    // Channel-index width; a single channel still needs one index bit.
    function automatic int unsigned ch_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/force_override_ctrl_if.sv
// Command handshake bundle for force_override_ctrl: valid/ready plus the
// opcode, target channel, force value and timed-hold payload.
interface force_override_ctrl_if
    import force_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned HOLD_W = 8,
    parameter int unsigned CH_W   = 2
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [OP_W-1:0]   cmd_op;
    logic [CH_W-1:0]   cmd_ch;
    logic [WIDTH-1:0]  cmd_value;
    logic [HOLD_W-1:0] cmd_hold;

    modport master (
        output cmd_valid, cmd_op, cmd_ch, cmd_value, cmd_hold,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_ch, cmd_value, cmd_hold,
        output cmd_ready
    );
endinterface

// File: rtl/force_chan.sv
// One overridable channel: held value, forced flag, timed-hold counter and the
// registered release pulse. A set strobe always beats clear and expiry.
module force_chan #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned HOLD_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  i_drv,
    input  logic              i_set,
    input  logic              i_timed,
    input  logic              i_clr,
    input  logic [WIDTH-1:0]  i_value,
    input  logic [HOLD_W-1:0] i_hold,
    output logic [WIDTH-1:0]  o_out,
    output logic              o_forced,
    output logic              o_rel_pulse
);

    logic [WIDTH-1:0]  r_value;
    logic [HOLD_W-1:0] r_cnt;
    logic              r_forced;
    logic              r_pulse;
    logic              w_expire;
    logic              w_forced_nxt;

    // A zero counter means an untimed force; the window closes on the 1->0 step.
    assign w_expire     = r_forced && (r_cnt == HOLD_W'(1));
    assign w_forced_nxt = i_set || (r_forced && !i_clr && !w_expire);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value  <= '0;
            r_cnt    <= '0;
            r_forced <= 1'b0;
            r_pulse  <= 1'b0;
        end else begin
            r_forced <= w_forced_nxt;
            r_pulse  <= r_forced && !w_forced_nxt;
            if (i_set) begin
                r_value <= i_value;
                r_cnt   <= i_timed ? i_hold : '0;
            end else if (i_clr) begin
                r_cnt <= '0;
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - HOLD_W'(1);
            end
        end
    end

    assign o_out       = r_forced ? r_value : i_drv;
    assign o_forced    = r_forced;
    assign o_rel_pulse = r_pulse;

endmodule

// File: rtl/force_override_ctrl.sv
// Multi-channel force/release override: command handshake, RELEASE_ALL sweep FSM,
// channel decode and sticky error, with one force_chan per overridable net.
module force_override_ctrl
    import force_pkg::*;
#(
    parameter int unsigned N_CH   = 4,
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned HOLD_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    force_override_ctrl_if.slave    cmd,
    input  logic [N_CH*WIDTH-1:0]   drv,
    output logic [N_CH*WIDTH-1:0]   out,
    output logic [N_CH-1:0]         forced,
    output logic [N_CH-1:0]         rel_pulse,
    output logic                    err
);

    localparam int unsigned CH_W = ch_width(N_CH);

    force_state_e     r_state;
    force_state_e     w_state_nxt;
    logic [CH_W-1:0]  r_idx;
    logic [CH_W-1:0]  w_idx_nxt;
    logic             w_ready;
    logic             r_err;
    force_op_e        w_op;
    logic             w_acc;
    logic             w_ch_ok;
    logic             w_ch_acc;
    logic [N_CH-1:0]  w_set;
    logic [N_CH-1:0]  w_clr;

    assign w_op     = force_op_e'(cmd.cmd_op);
    assign w_acc    = cmd.cmd_valid && w_ready;
    assign w_ch_ok  = 32'(cmd.cmd_ch) < N_CH;
    assign w_ch_acc = w_acc && w_ch_ok && (w_op != RELEASE_ALL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // SWEEP releases one channel per edge, index 0 first, then drops back to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_ready     = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready = 1'b1;
                if (cmd.cmd_valid && (w_op == RELEASE_ALL)) begin
                    w_state_nxt = SWEEP;
                    w_idx_nxt   = '0;
                end
            end
            SWEEP: begin
                if (r_idx == CH_W'(N_CH - 1)) begin
                    w_state_nxt = IDLE;
                    w_idx_nxt   = '0;
                end else begin
                    w_idx_nxt = r_idx + CH_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    assign cmd.cmd_ready = w_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_acc && !w_ch_ok && (w_op != RELEASE_ALL)) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic w_hit;

        assign w_hit    = w_ch_acc && (cmd.cmd_ch == CH_W'(c));
        assign w_set[c] = w_hit && ((w_op == FORCE) || (w_op == TFORCE));
        assign w_clr[c] = (w_hit && (w_op == RELEASE)) ||
                          ((r_state == SWEEP) && (r_idx == CH_W'(c)));

        force_chan #(
            .WIDTH  (WIDTH),
            .HOLD_W (HOLD_W)
        ) u_chan (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_drv       (drv[c*WIDTH +: WIDTH]),
            .i_set       (w_set[c]),
            .i_timed     (w_op == TFORCE),
            .i_clr       (w_clr[c]),
            .i_value     (cmd.cmd_value),
            .i_hold      (cmd.cmd_hold),
            .o_out       (out[c*WIDTH +: WIDTH]),
            .o_forced    (forced[c]),
            .o_rel_pulse (rel_pulse[c])
        );
    end

endmodule

// File: tb/tb_force_override_ctrl.sv
// Directed bench for force_override_ctrl: a 4-channel unit for the main flows and
// a 3-channel unit where an out-of-range channel index is encodable.
module tb_force_override_ctrl;
    import force_pkg::*;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned HOLD_W = 8;
    localparam int unsigned NA     = 4;
    localparam int unsigned NB     = 3;
    localparam int unsigned CWA    = ch_width(NA);
    localparam int unsigned CWB    = ch_width(NB);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NA*WIDTH-1:0] drv_a;
    logic [NA*WIDTH-1:0] out_a;
    logic [NA-1:0]       forced_a;
    logic [NA-1:0]       rel_a;
    logic                err_a;
    logic [NB*WIDTH-1:0] drv_b;
    logic [NB*WIDTH-1:0] out_b;
    logic [NB-1:0]       forced_b;
    logic [NB-1:0]       rel_b;
    logic                err_b;

    force_override_ctrl_if #(.WIDTH(WIDTH), .HOLD_W(HOLD_W), .CH_W(CWA)) ifa ();
    force_override_ctrl_if #(.WIDTH(WIDTH), .HOLD_W(HOLD_W), .CH_W(CWB)) ifb ();

    force_override_ctrl #(.N_CH(NA), .WIDTH(WIDTH), .HOLD_W(HOLD_W)) u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd       (ifa),
        .drv       (drv_a),
        .out       (out_a),
        .forced    (forced_a),
        .rel_pulse (rel_a),
        .err       (err_a)
    );

    force_override_ctrl #(.N_CH(NB), .WIDTH(WIDTH), .HOLD_W(HOLD_W)) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd       (ifb),
        .drv       (drv_b),
        .out       (out_b),
        .forced    (forced_b),
        .rel_pulse (rel_b),
        .err       (err_b)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WIDTH-1:0] sel_a(input int c);
        return out_a[c*WIDTH +: WIDTH];
    endfunction

    // Drive one command on unit A; returns in the cycle after the accepting edge.
    task automatic send_a(input force_op_e op, input int ch, input logic [7:0] val,
                          input logic [7:0] hold);
        int budget;
        budget        = 20;
        ifa.cmd_valid = 1'b1;
        ifa.cmd_op    = op;
        ifa.cmd_ch    = CWA'(ch);
        ifa.cmd_value = val;
        ifa.cmd_hold  = hold;
        #1;
        while (!ifa.cmd_ready && budget > 0) begin
            step();
            budget--;
        end
        chk($sformatf("ready_before_%s_ch%0d", op.name(), ch), 64'(ifa.cmd_ready), 64'd1);
        step();
        ifa.cmd_valid = 1'b0;
    endtask

    logic [NA-1:0] m;

    initial begin
        ifa.cmd_valid = 1'b0; ifa.cmd_op = '0; ifa.cmd_ch = '0; ifa.cmd_value = '0; ifa.cmd_hold = '0;
        ifb.cmd_valid = 1'b0; ifb.cmd_op = '0; ifb.cmd_ch = '0; ifb.cmd_value = '0; ifb.cmd_hold = '0;
        drv_a = {8'h44, 8'h33, 8'h11, 8'h00};
        drv_b = {8'hB2, 8'hB1, 8'hB0};

        // Reset state
        step(); step();
        chk("rst_forced", 64'(forced_a), 64'd0);
        chk("rst_rel",    64'(rel_a),    64'd0);
        chk("rst_err",    64'(err_a),    64'd0);
        chk("rst_ready",  64'(ifa.cmd_ready), 64'd1);
        chk("rst_out",    64'(out_a),    64'(drv_a));
        rst_n = 1'b1;
        step();

        // FORCE / drv isolation / RELEASE
        send_a(FORCE, 1, 8'hA5, 8'd0);
        chk("f1_out",    64'(sel_a(1)), 64'hA5);
        chk("f1_forced", 64'(forced_a), 64'b0010);
        drv_a[15:8] = 8'h5A;
        #1;
        chk("f1_drv_iso", 64'(sel_a(1)), 64'hA5);
        send_a(RELEASE, 1, 8'h00, 8'd0);
        chk("r1_forced", 64'(forced_a), 64'd0);
        chk("r1_out",    64'(sel_a(1)), 64'h5A);
        chk("r1_pulse",  64'(rel_a),    64'b0010);
        step();
        chk("r1_pulse_end", 64'(rel_a), 64'd0);

        // TFORCE ch2 hold 5
        send_a(TFORCE, 2, 8'h3C, 8'd5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("tf_forced_c%0d", i + 1), 64'(forced_a[2]), 64'd1);
            chk($sformatf("tf_out_c%0d", i + 1),    64'(sel_a(2)),    64'h3C);
            step();
        end
        chk("tf_exp_forced", 64'(forced_a), 64'd0);
        chk("tf_exp_out",    64'(sel_a(2)), 64'h33);
        chk("tf_exp_pulse",  64'(rel_a),    64'b0100);
        step();
        chk("tf_pulse_end",  64'(rel_a),    64'd0);

        // Force all, then RELEASE_ALL sweep
        for (int c = 0; c < 4; c++) send_a(FORCE, c, 8'(8'hC0 + c), 8'd0);
        chk("fa_forced", 64'(forced_a), 64'hF);
        chk("fa_out3",   64'(sel_a(3)), 64'hC3);
        send_a(RELEASE_ALL, 0, 8'h00, 8'd0);
        for (int j = 0; j < 4; j++) begin
            m = 4'hF << j;
            chk($sformatf("sw_ready_%0d", j),  64'(ifa.cmd_ready), 64'd0);
            chk($sformatf("sw_forced_%0d", j), 64'(forced_a), 64'(m));
            m = (j == 0) ? 4'b0000 : 4'(1 << (j - 1));
            chk($sformatf("sw_pulse_%0d", j),  64'(rel_a), 64'(m));
            step();
        end
        chk("sw_done_ready",  64'(ifa.cmd_ready), 64'd1);
        chk("sw_done_forced", 64'(forced_a), 64'd0);
        chk("sw_done_pulse",  64'(rel_a),    64'b1000);

        // FORCE landing on TFORCE expiry edge
        send_a(TFORCE, 0, 8'h11, 8'd2);
        chk("cf_tf_forced", 64'(forced_a[0]), 64'd1);
        step();
        send_a(FORCE, 0, 8'h7E, 8'd0);
        chk("cf_forced", 64'(forced_a[0]), 64'd1);
        chk("cf_out",    64'(sel_a(0)),    64'h7E);
        chk("cf_pulse",  64'(rel_a),       64'd0);
        step();
        chk("cf_forced_hold", 64'(forced_a[0]), 64'd1);
        chk("cf_pulse_hold",  64'(rel_a),       64'd0);
        send_a(RELEASE, 0, 8'h00, 8'd0);
        chk("cf_rel_pulse", 64'(rel_a), 64'b0001);

        // RELEASE on an unforced channel
        step();
        send_a(RELEASE, 3, 8'h00, 8'd0);
        chk("ru_pulse",  64'(rel_a),    64'd0);
        chk("ru_forced", 64'(forced_a), 64'd0);
        chk("ru_err",    64'(err_a),    64'd0);

        // Invalid channel on the 3-channel unit
        ifb.cmd_valid = 1'b1; ifb.cmd_op = FORCE; ifb.cmd_ch = CWB'(3); ifb.cmd_value = 8'h99;
        #1;
        chk("bad_ready", 64'(ifb.cmd_ready), 64'd1);
        step();
        ifb.cmd_valid = 1'b0;
        chk("bad_err",    64'(err_b),    64'd1);
        chk("bad_forced", 64'(forced_b), 64'd0);
        chk("bad_out",    64'(out_b),    64'(drv_b));
        step(); step();
        chk("bad_err_sticky", 64'(err_b), 64'd1);
        ifb.cmd_valid = 1'b1; ifb.cmd_op = FORCE; ifb.cmd_ch = CWB'(2); ifb.cmd_value = 8'h77;
        step();
        ifb.cmd_valid = 1'b0;
        chk("b_forced", 64'(forced_b), 64'b100);
        chk("b_out2",   64'(out_b[23:16]), 64'h77);
        chk("b_err_still", 64'(err_b), 64'd1);

        // Reset mid-SWEEP
        for (int c = 0; c < 4; c++) send_a(FORCE, c, 8'(8'hD0 + c), 8'd0);
        send_a(RELEASE_ALL, 0, 8'h00, 8'd0);
        step();
        chk("ms_pre_forced", 64'(forced_a), 64'b1110);
        rst_n = 1'b0;
        #1;
        chk("ms_rst_ready",  64'(ifa.cmd_ready), 64'd1);
        chk("ms_rst_forced", 64'(forced_a), 64'd0);
        chk("ms_rst_pulse",  64'(rel_a),    64'd0);
        chk("ms_rst_out",    64'(out_a),    64'(drv_a));
        chk("ms_rst_err_b",  64'(err_b),    64'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("ms_post_pulse_%0d", i),  64'(rel_a),    64'd0);
            chk($sformatf("ms_post_forced_%0d", i), 64'(forced_a), 64'd0);
        end

        // Reset mid-TFORCE
        send_a(TFORCE, 3, 8'hEE, 8'd10);
        step(); step();
        chk("mt_pre_out", 64'(sel_a(3)), 64'hEE);
        rst_n = 1'b0;
        #1;
        chk("mt_rst_forced", 64'(forced_a), 64'd0);
        chk("mt_rst_out",    64'(out_a),    64'(drv_a));
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            chk($sformatf("mt_post_pulse_%0d", i), 64'(rel_a), 64'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
